// File: rtl/bt656_sync_encoder.sv
// BT.656 transmit encoder: 625-line 4:2:2 line/field timing generator that
// emits EAV/SAV timing codes, horizontal/vertical blanking words and clipped
// active-video words pulled from an upstream source over valid/ready.
//
// Handshake: pix_ready depends only on the line/word counters. A word is
// transferred on a rising clk edge where pix_valid && pix_ready; that word
// appears on bt656 one cycle later. The encoder never stalls; a missing word
// is replaced by a blanking word and flags underflow (sticky until reset).
module bt656_sync_encoder #(
    parameter int ACTIVE_WORDS = 1440,
    parameter int BLANK_WORDS  = 280,
    parameter int LINES        = 625,
    parameter int F1_FIRST     = 313,
    parameter int VACT0_FIRST  = 23,
    parameter int VACT0_LAST   = 310,
    parameter int VACT1_FIRST  = 336,
    parameter int VACT1_LAST   = 623
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [9:0] bt656,
    output logic       H,
    output logic       V,
    output logic       F,
    output logic       frame_start,
    output logic       underflow
);

    localparam int LINE_WORDS = 8 + BLANK_WORDS + ACTIVE_WORDS;
    localparam int WCW        = $clog2(LINE_WORDS);
    localparam int LNW        = $clog2(LINES + 1);

    localparam logic [WCW-1:0] LAST_WORD   = WCW'(LINE_WORDS - 1);
    localparam logic [WCW-1:0] BLANK_START = WCW'(4);
    localparam logic [WCW-1:0] SAV_START   = WCW'(BLANK_WORDS + 4);
    localparam logic [WCW-1:0] ACT_START   = WCW'(BLANK_WORDS + 8);

    localparam logic [LNW-1:0] FIRST_LINE  = LNW'(1);
    localparam logic [LNW-1:0] LAST_LINE   = LNW'(LINES);
    localparam logic [LNW-1:0] F1_LINE     = LNW'(F1_FIRST);
    localparam logic [LNW-1:0] V0_FIRST    = LNW'(VACT0_FIRST);
    localparam logic [LNW-1:0] V0_LAST     = LNW'(VACT0_LAST);
    localparam logic [LNW-1:0] V1_FIRST    = LNW'(VACT1_FIRST);
    localparam logic [LNW-1:0] V1_LAST     = LNW'(VACT1_LAST);

    logic [WCW-1:0] word_cnt;
    logic [LNW-1:0] line;

    logic       line_f;
    logic       line_v;
    logic       h_now;
    logic       in_eav;
    logic       in_sav;
    logic       in_act;
    logic [1:0] code_pos;
    logic       blank_odd;
    logic [7:0] blank_word;
    logic [7:0] clip_data;
    logic [7:0] xy;
    logic [7:0] next_word;

    // Word and line counters; line advances when the word counter wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            line     <= FIRST_LINE;
        end else if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            line     <= (line == LAST_LINE) ? FIRST_LINE : line + 1'b1;
        end else begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Decode the current counter position into flags and the word to emit.
    always_comb begin
        line_f     = (line >= F1_LINE);
        line_v     = !(((line >= V0_FIRST) && (line <= V0_LAST)) ||
                       ((line >= V1_FIRST) && (line <= V1_LAST)));
        in_eav     = (word_cnt < BLANK_START);
        in_sav     = (word_cnt >= SAV_START) && (word_cnt < ACT_START);
        in_act     = (word_cnt >= ACT_START);
        h_now      = (word_cnt < SAV_START);
        // Offset within the 4-word code, and parity of the offset from the
        // end of the preceding code (blanking alternates 80/10 from there).
        code_pos   = 2'(in_sav ? word_cnt - SAV_START : word_cnt);
        blank_odd  = 1'(in_act ? word_cnt - ACT_START : word_cnt - BLANK_START);
        blank_word = blank_odd ? 8'h10 : 8'h80;
        pix_ready  = in_act && !line_v;
        xy         = {1'b1, line_f, line_v, h_now,
                      line_v ^ h_now, line_f ^ h_now, line_f ^ line_v,
                      line_f ^ line_v ^ h_now};
        // 00 and FF are reserved for timing codes and must not leak from video.
        clip_data  = pix_data;
        if (pix_data == 8'h00) clip_data = 8'h01;
        if (pix_data == 8'hFF) clip_data = 8'hFE;
        next_word  = blank_word;
        if (in_eav || in_sav) begin
            case (code_pos)
                2'd0:    next_word = 8'hFF;
                2'd3:    next_word = xy;
                default: next_word = 8'h00;
            endcase
        end else if (pix_ready && pix_valid) begin
            next_word = clip_data;
        end
    end

    // Output register: word, timing flags, frame pulse and sticky underflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bt656       <= 10'h200;
            H           <= 1'b1;
            V           <= 1'b1;
            F           <= 1'b1;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            bt656       <= {next_word, 2'b00};
            H           <= h_now;
            V           <= line_v;
            F           <= line_f;
            frame_start <= (word_cnt == '0) && (line == FIRST_LINE);
            if (pix_ready && !pix_valid) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bt656_sync_encoder.sv
// Bench for bt656_sync_encoder. Uses a short line (16 active, 8 blanking
// words) with the full 625-line field structure so a whole frame is walked.
// Expected words come from a position-based model: line and word position
// are derived from the number of words emitted since reset release.
module tb_bt656_sync_encoder;

    localparam int ACT = 16;
    localparam int BLK = 8;
    localparam int NL  = 625;
    localparam int LW  = ACT + BLK + 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] bt656;
    logic       H;
    logic       V;
    logic       F;
    logic       frame_start;
    logic       underflow;

    int   total = 0;
    int   bad   = 0;
    int   cur_idx;
    logic uf_model;
    int   rdy22 = 0;
    int   rdy23 = 0;

    // clock / reset
    always #5 clk = ~clk;

    bt656_sync_encoder #(
        .ACTIVE_WORDS(ACT),
        .BLANK_WORDS (BLK),
        .LINES       (NL),
        .F1_FIRST    (313),
        .VACT0_FIRST (23),
        .VACT0_LAST  (310),
        .VACT1_FIRST (336),
        .VACT1_LAST  (623)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .bt656      (bt656),
        .H          (H),
        .V          (V),
        .F          (F),
        .frame_start(frame_start),
        .underflow  (underflow)
    );

    // ---------------- model ----------------
    function automatic int line_of(input int idx);
        return (idx / LW) % NL + 1;
    endfunction

    function automatic int pos_of(input int idx);
        return idx % LW;
    endfunction

    function automatic bit f_of(input int ln);
        return ln >= 313;
    endfunction

    function automatic bit v_of(input int ln);
        return !((ln >= 23 && ln <= 310) || (ln >= 336 && ln <= 623));
    endfunction

    function automatic logic [7:0] xy_of(input bit f, input bit v, input bit h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic bit is_code(input int p);
        return (p < 4) || (p >= BLK + 4 && p < BLK + 8);
    endfunction

    function automatic logic [7:0] word_of(input int idx, input bit valid, input logic [7:0] d);
        int ln, p, k;
        ln = line_of(idx);
        p  = pos_of(idx);
        if (is_code(p)) begin
            k = (p < 4) ? p : p - (BLK + 4);
            if (k == 0) return 8'hFF;
            if (k == 3) return xy_of(f_of(ln), v_of(ln), p < 4);
            return 8'h00;
        end
        if (p < BLK + 4) return ((p - 4) % 2 == 1) ? 8'h10 : 8'h80;
        if (v_of(ln) || !valid) return ((p - (BLK + 8)) % 2 == 1) ? 8'h10 : 8'h80;
        if (d == 8'h00) return 8'h01;
        if (d == 8'hFF) return 8'hFE;
        return d;
    endfunction

    // Hand-computed XY bytes at the lines where F/V change.
    function automatic int lit_xy(input int ln, input int p);
        bit eav;
        if (p == 3) eav = 1'b1;
        else if (p == BLK + 7) eav = 1'b0;
        else return -1;
        case (ln)
            1, 22, 311:    return eav ? 32'hB6 : 32'hAB;
            23, 310:       return eav ? 32'h9D : 32'h80;
            336, 623:      return eav ? 32'hDA : 32'hC7;
            313, 624, 625: return eav ? 32'hF1 : 32'hEC;
            default:       return -1;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s idx=%0d actual=%h expected=%h", nm, cur_idx, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bt656"}, 32'(bt656), 32'h200);
        chk({tag, "_hvf"}, 32'({H, V, F}), 32'h7);
        chk({tag, "_ready"}, 32'(pix_ready), 32'h0);
        chk({tag, "_fs"}, 32'(frame_start), 32'h0);
        chk({tag, "_uf"}, 32'(underflow), 32'h0);
    endtask

    // ---------------- driver: one word slot ----------------
    task automatic step(input bit v, input logic [7:0] d);
        int ln, p, lit;
        bit rdy_exp;
        logic [7:0] exp_w;
        bit exp_h, exp_v, exp_f, exp_fs;
        ln = line_of(cur_idx);
        p  = pos_of(cur_idx);
        rdy_exp = !v_of(ln) && (p >= BLK + 8);
        chk("pix_ready", 32'(pix_ready), 32'(rdy_exp));
        if (cur_idx < NL * LW) begin
            if (ln == 22 && pix_ready) rdy22++;
            if (ln == 23 && pix_ready) rdy23++;
        end
        pix_valid = v;
        pix_data  = d;
        exp_w  = word_of(cur_idx, v, d);
        exp_h  = p < BLK + 4;
        exp_v  = v_of(ln);
        exp_f  = f_of(ln);
        exp_fs = (p == 0) && (ln == 1);
        if (rdy_exp && !v) uf_model = 1'b1;
        @(negedge clk);
        chk("bt656", 32'(bt656), 32'({exp_w, 2'b00}));
        chk("flags", 32'({H, V, F, frame_start, underflow}),
            32'({exp_h, exp_v, exp_f, exp_fs, uf_model}));
        if (!is_code(p)) chk("no_ff", 32'(bt656[9:2] == 8'hFF), 32'h0);
        lit = lit_xy(ln, p);
        if (lit >= 0) chk("xy_lit", 32'(bt656[9:2]), 32'(lit));
        cur_idx++;
    endtask

    function automatic logic [7:0] rand_data();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int ln, p;
        bit v;
        reset_n   = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        cur_idx   = 0;
        uf_model  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        reset_n = 1'b1;

        // first word after release: EAV FF with frame_start
        step(1'b1, rand_data());
        chk("first_ff", 32'(bt656), 32'h3FC);
        chk("first_fs", 32'(frame_start), 32'h1);

        // one full frame plus up to line 100 of the next
        while (cur_idx < NL * LW + 99 * LW + 20) begin
            ln = line_of(cur_idx);
            p  = pos_of(cur_idx);
            if (cur_idx == 49 * LW) chk("uf_before", 32'(underflow), 32'h0);
            if (cur_idx == 50 * LW) chk("uf_after", 32'(underflow), 32'h1);
            if (cur_idx < 49 * LW) v = 1'b1;
            else if (cur_idx < 50 * LW) v = !(p >= BLK + 13 && p <= BLK + 15);
            else v = ($urandom_range(0, 9) != 0);
            step(v, rand_data());
        end
        chk("uf_sticky", 32'(underflow), 32'h1);
        chk("ready_line22", 32'(rdy22), 32'h0);
        chk("ready_line23", 32'(rdy23), 32'(ACT));

        // mid-line reset on line 100
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        chk_reset_vals("rst_hold");
        reset_n  = 1'b1;
        cur_idx  = 0;
        uf_model = 1'b0;
        step(1'b1, rand_data());
        chk("post_rst_ff", 32'(bt656), 32'h3FC);
        chk("post_rst_fs", 32'(frame_start), 32'h1);
        while (cur_idx < 3 * LW) begin
            step($urandom_range(0, 9) != 0, rand_data());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
